// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
// Controller states plus the clog2/way-width helpers used to derive field widths.
package cache_ctrl_assoc_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_MONITOR,
        ST_WB,
        ST_FETCH,
        ST_FL_SCAN,
        ST_FL_WB,
        ST_FL_END
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero, used for way and line pointers.
    function automatic int unsigned min1_clog2(input int unsigned v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/cache_ctrl_assoc_victim_sel.sv
// Victim way choice: the lowest-index invalid way wins, otherwise the round-robin pointer.
module cache_victim_sel
    import cache_ctrl_assoc_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] rr,
    output logic [WAY_W-1:0] victim,
    output logic             from_rr
);

    always_comb begin
        victim  = rr;
        from_rr = 1'b1;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid[i] && from_rr) begin
                victim  = WAY_W'(i);
                from_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative write-back/write-allocate cache controller with
// round-robin replacement, full-cache flush and saturating hit/miss counters.
module cache_ctrl_assoc
    import cache_ctrl_assoc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 8,
    parameter int WORDS  = 2,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [ADDR_W-1:0]                         pr_addr,
    input  logic [WORD_W-1:0]                         pr_din,
    input  logic                                      pr_rd,
    input  logic                                      pr_wr,
    output logic [WORD_W-1:0]                         pr_dout,
    output logic                                      pr_done,
    input  logic                                      flush,
    output logic                                      flush_done,
    output logic [ADDR_W-clog2(WORDS)-1:0]            bus_addr,
    output logic [WORD_W*WORDS-1:0]                   bus_dout,
    input  logic [WORD_W*WORDS-1:0]                   bus_din,
    output logic                                      bus_rd,
    output logic                                      bus_wr,
    input  logic                                      bus_done,
    output logic [CNT_W-1:0]                          hit_cnt,
    output logic [CNT_W-1:0]                          miss_cnt
);

    localparam int OFF_W   = clog2(WORDS);
    localparam int IDX_W   = clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W   = min1_clog2(WAYS);
    localparam int LINES   = SETS * WAYS;
    localparam int PTR_W   = min1_clog2(LINES);
    localparam int WAY_SH  = clog2(WAYS);
    localparam int BLK_W   = WORD_W * WORDS;

    state_e                 state_q, state_d;
    logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]       tag_d   [SETS][WAYS];
    logic [BLK_W-1:0]       data_q  [SETS][WAYS];
    logic [BLK_W-1:0]       data_d  [SETS][WAYS];
    logic [WAYS-1:0]        valid_q [SETS];
    logic [WAYS-1:0]        valid_d [SETS];
    logic [WAYS-1:0]        dirty_q [SETS];
    logic [WAYS-1:0]        dirty_d [SETS];
    logic [WAY_W-1:0]       rr_q    [SETS];
    logic [WAY_W-1:0]       rr_d    [SETS];
    logic [WAY_W-1:0]       victim_q, victim_d;
    logic                   victim_rr_q, victim_rr_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]      miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]       req_tag, m_tag;
    logic [IDX_W-1:0]       req_idx, m_idx, p_idx;
    logic [OFF_W-1:0]       req_off, m_off;
    logic [WAY_W-1:0]       p_way, hit_way, vs_victim;
    logic                   req, hit, vs_from_rr, p_last;
    logic [BLK_W-1:0]       fill_blk;

    assign {req_tag, req_idx, req_off} = pr_addr;
    assign {m_tag, m_idx, m_off}       = miss_addr_q;
    assign req    = pr_rd | pr_wr;
    assign p_idx  = IDX_W'(ptr_q >> WAY_SH);
    assign p_way  = WAY_W'(ptr_q & PTR_W'(WAYS - 1));
    assign p_last = (ptr_q == PTR_W'(LINES - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign pr_dout = data_q[req_idx][hit_way][req_off*WORD_W +: WORD_W];

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid   (valid_q[req_idx]),
        .rr      (rr_q[req_idx]),
        .victim  (vs_victim),
        .from_rr (vs_from_rr)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        data_d      = data_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rr_d        = rr_q;
        victim_d    = victim_q;
        victim_rr_d = victim_rr_q;
        ptr_d       = ptr_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        pr_done     = 1'b0;
        flush_done  = 1'b0;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_addr    = '0;
        bus_dout    = '0;
        fill_blk    = bus_din;

        case (state_q)
            ST_INIT: begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_d[s] = '0;
                    dirty_d[s] = '0;
                    rr_d[s]    = '0;
                end
                state_d = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (req && hit) begin
                    pr_done = 1'b1;
                    if (pr_wr) begin
                        data_d[req_idx][hit_way][req_off*WORD_W +: WORD_W] = pr_din;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                    if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
                end else if (req) begin
                    if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
                    victim_d    = vs_victim;
                    victim_rr_d = vs_from_rr;
                    miss_addr_d = pr_addr;
                    state_d = (valid_q[req_idx][vs_victim] && dirty_q[req_idx][vs_victim])
                              ? ST_WB : ST_FETCH;
                end else if (flush) begin
                    ptr_d   = '0;
                    state_d = ST_FL_SCAN;
                end
            end
            ST_WB: begin
                bus_wr   = 1'b1;
                bus_addr = {tag_q[m_idx][victim_q], m_idx};
                bus_dout = data_q[m_idx][victim_q];
                if (bus_done) begin
                    dirty_d[m_idx][victim_q] = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                bus_rd   = 1'b1;
                bus_addr = miss_addr_q[ADDR_W-1:OFF_W];
                if (bus_done) begin
                    // A write still pending at fill time is merged so the line lands dirty.
                    if (pr_wr) fill_blk[m_off*WORD_W +: WORD_W] = pr_din;
                    tag_d[m_idx][victim_q]   = m_tag;
                    data_d[m_idx][victim_q]  = fill_blk;
                    valid_d[m_idx][victim_q] = 1'b1;
                    dirty_d[m_idx][victim_q] = pr_wr;
                    if (victim_rr_q) begin
                        rr_d[m_idx] = (rr_q[m_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[m_idx] + 1'b1;
                    end
                    state_d = ST_MONITOR;
                end
            end
            ST_FL_SCAN: begin
                if (valid_q[p_idx][p_way] && dirty_q[p_idx][p_way]) begin
                    state_d = ST_FL_WB;
                end else if (p_last) begin
                    state_d = ST_FL_END;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_FL_WB: begin
                bus_wr   = 1'b1;
                bus_addr = {tag_q[p_idx][p_way], p_idx};
                bus_dout = data_q[p_idx][p_way];
                if (bus_done) begin
                    dirty_d[p_idx][p_way] = 1'b0;
                    if (p_last) begin
                        state_d = ST_FL_END;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_FL_SCAN;
                    end
                end
            end
            ST_FL_END: begin
                flush_done = 1'b1;
                state_d    = ST_MONITOR;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            ptr_q       <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            victim_q    <= victim_d;
            victim_rr_q <= victim_rr_d;
            ptr_q       <= ptr_d;
            miss_addr_q <= miss_addr_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            rr_q        <= rr_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed self-checking bench for cache_ctrl_assoc at default geometry.
module tb_cache_ctrl_assoc;

    logic        clk;
    logic        reset_n;
    logic [5:0]  pr_addr;
    logic [7:0]  pr_din;
    logic        pr_rd;
    logic        pr_wr;
    logic [7:0]  pr_dout;
    logic        pr_done;
    logic        flush;
    logic        flush_done;
    logic [4:0]  bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_done;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    cache_ctrl_assoc #(
        .ADDR_W (6),
        .WORD_W (8),
        .WORDS  (2),
        .SETS   (4),
        .WAYS   (2),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pr_addr    (pr_addr),
        .pr_din     (pr_din),
        .pr_rd      (pr_rd),
        .pr_wr      (pr_wr),
        .pr_dout    (pr_dout),
        .pr_done    (pr_done),
        .flush      (flush),
        .flush_done (flush_done),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_done   (bus_done),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: drives one processor request, services bus transfers
    // immediately, and reports what it saw. cyc is the cycle index of pr_done.
    task automatic access(input logic [5:0] a, input logic wr, input logic [7:0] d,
                          input logic [15:0] fill, output logic [7:0] dout,
                          output int n_rd, output int n_wr, output logic [4:0] rd_addr,
                          output logic [4:0] wr_addr, output logic [15:0] wr_data,
                          output int cyc, output logic tmo);
        n_rd = 0; n_wr = 0; cyc = -1; tmo = 1'b1;
        dout = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        pr_addr = a; pr_din = d; pr_wr = wr; pr_rd = !wr;
        for (int i = 0; i < 40 && tmo; i++) begin
            #2;
            if (pr_done) begin
                dout = pr_dout; cyc = i; tmo = 1'b0;
            end else if (bus_rd) begin
                n_rd++; rd_addr = bus_addr; bus_din = fill; bus_done = 1'b1;
            end else if (bus_wr) begin
                n_wr++; wr_addr = bus_addr; wr_data = bus_dout; bus_done = 1'b1;
            end
            @(posedge clk);
            #1 bus_done = 1'b0;
        end
        pr_rd = 1'b0; pr_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pr_addr = '0; pr_din = '0; pr_rd = 1'b0; pr_wr = 1'b0;
        flush = 1'b0; bus_din = '0; bus_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd got %b want 0", bus_rd); end
        checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL reset_bus_wr got %b want 0", bus_wr); end
        checks++; if (bus_addr !== 5'h00) begin errors++; $display("FAIL reset_bus_addr got %h want 00", bus_addr); end
        checks++; if (bus_dout !== 16'h0000) begin errors++; $display("FAIL reset_bus_dout got %h want 0000", bus_dout); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
        checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
        checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss_cnt got %0d want 0", miss_cnt); end
        pr_rd = 1'b1; pr_addr = 6'h05; #1;
        checks++; if (pr_done !== 1'b0) begin errors++; $display("FAIL reset_pr_done got %b want 0", pr_done); end
        pr_rd = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        access(6'h05, 1'b0, 8'h00, 16'hBEEF, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL miss_timeout got %b want 0", tmo); end
        checks++; if (n_rd !== 1 || ra !== 5'h02) begin errors++; $display("FAIL miss_fetch got n=%0d addr=%h want n=1 addr=02", n_rd, ra); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL miss_no_wb got %0d want 0", n_wr); end
        checks++; if (dout !== 8'hBE) begin errors++; $display("FAIL miss_dout got %h want BE", dout); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL miss_latency got %0d want 2", cyc); end
        checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1) begin errors++; $display("FAIL miss_counts got miss=%0d hit=%0d want 1/1", miss_cnt, hit_cnt); end
    endtask

    task automatic test_write_hit();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        access(6'h04, 1'b1, 8'h11, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || n_rd !== 0 || n_wr !== 0) begin errors++; $display("FAIL write_hit got cyc=%0d rd=%0d wr=%0d want 0/0/0", cyc, n_rd, n_wr); end
        access(6'h04, 1'b0, 8'h00, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || dout !== 8'h11) begin errors++; $display("FAIL read_after_write got cyc=%0d dout=%h want 0/11", cyc, dout); end
    endtask

    task automatic test_second_way();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        access(6'h0D, 1'b0, 8'h00, 16'h1234, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (n_rd !== 1 || ra !== 5'h06 || n_wr !== 0 || dout !== 8'h12) begin
            errors++; $display("FAIL way1_fill got rd=%0d addr=%h wr=%0d dout=%h want 1/06/0/12", n_rd, ra, n_wr, dout); end
        access(6'h05, 1'b0, 8'h00, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || n_rd !== 0 || dout !== 8'hBE) begin errors++; $display("FAIL way0_hit got cyc=%0d rd=%0d dout=%h want 0/0/BE", cyc, n_rd, dout); end
        access(6'h0D, 1'b0, 8'h00, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || n_rd !== 0 || dout !== 8'h12) begin errors++; $display("FAIL way1_hit got cyc=%0d rd=%0d dout=%h want 0/0/12", cyc, n_rd, dout); end
    endtask

    task automatic test_evict();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        access(6'h15, 1'b0, 8'h00, 16'h5678, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (n_wr !== 1 || wa !== 5'h02 || wd !== 16'hBE11) begin
            errors++; $display("FAIL evict_wb got n=%0d addr=%h data=%h want 1/02/BE11", n_wr, wa, wd); end
        checks++; if (n_rd !== 1 || ra !== 5'h0A || dout !== 8'h56 || cyc !== 3) begin
            errors++; $display("FAIL evict_fetch got n=%0d addr=%h dout=%h cyc=%0d want 1/0A/56/3", n_rd, ra, dout, cyc); end
        checks++; if (miss_cnt !== 16'd3 || hit_cnt !== 16'd7) begin errors++; $display("FAIL evict_counts got miss=%0d hit=%0d want 3/7", miss_cnt, hit_cnt); end
        access(6'h0D, 1'b0, 8'h00, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || dout !== 8'h12) begin errors++; $display("FAIL evict_other_way got cyc=%0d dout=%h want 0/12", cyc, dout); end
    endtask

    task automatic test_flush();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        logic [4:0] fa [2]; logic [15:0] fd [2]; int nw, pulses, first, rd_seen;
        access(6'h02, 1'b1, 8'hA5, 16'h3344, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        access(6'h06, 1'b0, 8'h00, 16'h1111, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        access(6'h0E, 1'b1, 8'h5A, 16'h7788, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (miss_cnt !== 16'd6 || hit_cnt !== 16'd11) begin errors++; $display("FAIL pre_flush_counts got miss=%0d hit=%0d want 6/11", miss_cnt, hit_cnt); end
        for (int pass = 0; pass < 2; pass++) begin
            fa[0] = '0; fa[1] = '0; fd[0] = '0; fd[1] = '0;
            nw = 0; pulses = 0; first = -1; rd_seen = 0;
            @(negedge clk) flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (flush_done) begin pulses++; if (first < 0) first = n; end
                if (bus_rd) rd_seen++;
                if (bus_wr) begin
                    if (nw < 2) begin fa[nw] = bus_addr; fd[nw] = bus_dout; end
                    nw++; bus_done = 1'b1;
                end
                @(posedge clk); #1 bus_done = 1'b0;
            end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL flush%0d_pulses got %0d want 1", pass, pulses); end
            checks++; if (rd_seen !== 0) begin errors++; $display("FAIL flush%0d_no_rd got %0d want 0", pass, rd_seen); end
            if (pass == 0) begin
                checks++; if (nw !== 2) begin errors++; $display("FAIL flush_wb_count got %0d want 2", nw); end
                checks++; if (fa[0] !== 5'h01 || fd[0] !== 16'h33A5) begin errors++; $display("FAIL flush_wb0 got %h/%h want 01/33A5", fa[0], fd[0]); end
                checks++; if (fa[1] !== 5'h07 || fd[1] !== 16'h775A) begin errors++; $display("FAIL flush_wb1 got %h/%h want 07/775A", fa[1], fd[1]); end
                checks++; if (first !== 11) begin errors++; $display("FAIL flush_dirty_latency got %0d want 11", first); end
            end else begin
                checks++; if (nw !== 0) begin errors++; $display("FAIL flush_clean_wb got %0d want 0", nw); end
                checks++; if (first !== 9) begin errors++; $display("FAIL flush_clean_latency got %0d want 9", first); end
            end
        end
        access(6'h02, 1'b0, 8'h00, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0 || n_rd !== 0 || dout !== 8'hA5) begin errors++; $display("FAIL post_flush_hit got cyc=%0d rd=%0d dout=%h want 0/0/A5", cyc, n_rd, dout); end
    endtask

    task automatic test_reset_mid_wb();
        logic [7:0] dout; int n_rd, n_wr, cyc; logic [4:0] ra, wa; logic [15:0] wd; logic tmo;
        access(6'h14, 1'b1, 8'h99, 16'h0000, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL mwb_setup_hit got cyc=%0d want 0", cyc); end
        access(6'h1D, 1'b0, 8'h00, 16'hAAAA, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (n_wr !== 0 || n_rd !== 1 || dout !== 8'hAA) begin errors++; $display("FAIL mwb_rr_victim got wr=%0d rd=%0d dout=%h want 0/1/AA", n_wr, n_rd, dout); end
        @(negedge clk);
        pr_addr = 6'h25; pr_rd = 1'b1; bus_done = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++; if (bus_wr !== 1'b1 || bus_rd !== 1'b0 || pr_done !== 1'b0) begin
                errors++; $display("FAIL mwb_hold got wr=%b rd=%b done=%b want 1/0/0", bus_wr, bus_rd, pr_done); end
            checks++; if (bus_addr !== 5'h0A || bus_dout !== 16'h5699) begin
                errors++; $display("FAIL mwb_data got %h/%h want 0A/5699", bus_addr, bus_dout); end
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        pr_rd = 1'b0;
        checks++; if (bus_wr !== 1'b0 || bus_rd !== 1'b0) begin errors++; $display("FAIL mwb_reset_bus got wr=%b rd=%b want 0/0", bus_wr, bus_rd); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL mwb_reset_cnt got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        access(6'h14, 1'b0, 8'h00, 16'hCDEF, dout, n_rd, n_wr, ra, wa, wd, cyc, tmo);
        checks++; if (n_rd !== 1 || ra !== 5'h0A || n_wr !== 0 || dout !== 8'hEF) begin
            errors++; $display("FAIL post_reset_miss got rd=%0d addr=%h wr=%0d dout=%h want 1/0A/0/EF", n_rd, ra, n_wr, dout); end
        checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1) begin errors++; $display("FAIL post_reset_counts got miss=%0d hit=%0d want 1/1", miss_cnt, hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_second_way();
        test_evict();
        test_flush();
        test_reset_mid_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
